// File: rtl/mips_data_memory.sv
// Word-addressed MIPS data segment: combinational read, clocked write, range/alignment checking.
// Optional build macro DMEM_BYTE_EN adds the byte_en port for per-lane stores.
module mips_data_memory #(
   parameter logic [31:0] BASE_ADDR   = 32'h7FFF0000,
   parameter int unsigned DEPTH_WORDS = 16384
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
`ifdef DMEM_BYTE_EN
   input  logic [3:0]  byte_en,
`endif
   output logic [31:0] read_data,
   output logic        addr_error,
   output logic        fault_sticky
);

   localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
   localparam int unsigned WOFF_W  = 31;
   localparam int unsigned LANES   = 4;

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [WOFF_W-1:0] word_off_c;
   logic [IDX_W-1:0]  idx_c;
   logic              in_range_c;
   logic              aligned_c;
   logic              addr_error_c;
   logic [LANES-1:0]  lane_en_c;
   logic [31:0]       wr_data_d;
   logic              wr_en_c;
   logic              fault_sticky_d;
   logic              fault_sticky_q;

`ifdef DMEM_BYTE_EN
   assign lane_en_c = byte_en;
`else
   assign lane_en_c = 4'hF;
`endif

   // Word offset with a borrow bit so addresses below the base never alias into the array.
   always_comb begin
      word_off_c   = {1'b0, address[31:2]} - {1'b0, BASE_ADDR[31:2]};
      in_range_c   = !word_off_c[WOFF_W-1] && (word_off_c[WOFF_W-2:0] < 30'(DEPTH_WORDS));
      aligned_c    = (address[1:0] == 2'b00);
      addr_error_c = !(in_range_c && aligned_c);
      idx_c        = word_off_c[IDX_W-1:0];
   end

   assign addr_error = addr_error_c;
   assign read_data  = addr_error_c ? 32'h0 : mem_q[idx_c];

   // Lane merge of the store data over the current word.
   always_comb begin
      wr_data_d = mem_q[idx_c];
      for (int unsigned i = 0; i < LANES; i++) begin
         if (lane_en_c[i]) begin
            wr_data_d[8*i +: 8] = write_data[8*i +: 8];
         end
      end
      wr_en_c = reset_n && mem_write && !addr_error_c && (lane_en_c != 4'h0);
   end

   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[idx_c] <= wr_data_d;
      end
   end

   always_comb begin
      fault_sticky_d = fault_sticky_q;
      if (mem_write && addr_error_c) begin
         fault_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_sticky_q <= 1'b0;
      end else begin
         fault_sticky_q <= fault_sticky_d;
      end
   end

   assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed self-checking bench for mips_data_memory (default and DMEM_BYTE_EN builds).
module tb_mips_data_memory;

   logic        clk;
   logic        reset_n;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
`ifdef DMEM_BYTE_EN
   logic [3:0]  byte_en;
`endif
   logic [31:0] read_data;
   logic        addr_error;
   logic        fault_sticky;

   int n_checks;
   int n_fail;

   mips_data_memory dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .mem_write    (mem_write),
      .address      (address),
      .write_data   (write_data),
`ifdef DMEM_BYTE_EN
      .byte_en      (byte_en),
`endif
      .read_data    (read_data),
      .addr_error   (addr_error),
      .fault_sticky (fault_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a write in the low phase, commit on the next rising edge, settle 1 time unit.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      write_data = d;
      mem_write  = 1'b1;
      @(posedge clk);
      #1;
      mem_write  = 1'b0;
   endtask

   task automatic read_at(input logic [31:0] a);
      address = a;
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      mem_write  = 1'b0;
      address    = 32'h7FFF0000;
      write_data = 32'h0;
`ifdef DMEM_BYTE_EN
      byte_en    = 4'hF;
`endif
      #1;
      check("rst_fault", 32'(fault_sticky), 32'h0);
      check("rst_err_base", 32'(addr_error), 32'h0);
      read_at(32'h00000000);
      check("rst_err_zero", 32'(addr_error), 32'h1);
      check("rst_rd_zero", read_data, 32'h0);

      @(negedge clk);
      reset_n = 1'b1;

      // First store and readback
      do_write(32'h7FFF0000, 32'hDEADBEEF);
      read_at(32'h7FFF0000);
      check("wr0_rd", read_data, 32'hDEADBEEF);
      check("wr0_err", 32'(addr_error), 32'h0);
      check("wr0_fault", 32'(fault_sticky), 32'h0);

      // Read-during-write sees the old word before the edge
      @(negedge clk);
      address    = 32'h7FFF0000;
      write_data = 32'h11112222;
      mem_write  = 1'b1;
      #1;
      check("rdw_old", read_data, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      check("rdw_new", read_data, 32'h11112222);

      // Sweep every 16 bytes across the segment
      for (int i = 0; i < 4096; i++) begin
         do_write(32'h7FFF0000 + 32'(i) * 32'h10, 32'h7FFF0000 + 32'(i) * 32'h10);
      end
      for (int i = 0; i < 4096; i++) begin
         read_at(32'h7FFF0000 + 32'(i) * 32'h10);
         check("sweep_rd", read_data, 32'h7FFF0000 + 32'(i) * 32'h10);
      end
      check("sweep_err", 32'(addr_error), 32'h0);
      read_at(32'h80000000);
      check("above_err", 32'(addr_error), 32'h1);
      check("above_rd", read_data, 32'h0);
      read_at(32'h7FFEFFFC);
      check("below_err", 32'(addr_error), 32'h1);
      read_at(32'h7FFFFFFE);
      check("top_misal_err", 32'(addr_error), 32'h1);
      check("fault_after_sweep", 32'(fault_sticky), 32'h0);

      do_write(32'h7FFF0000, 32'hDEADBEEF);

      // Top word, then illegal writes that would alias if arithmetic wrapped
      do_write(32'h7FFFFFFC, 32'h12345678);
      read_at(32'h7FFFFFFC);
      check("top_rd", read_data, 32'h12345678);
      check("top_err", 32'(addr_error), 32'h0);
      read_at(32'h7FFFFFF0);
      check("top_nbr", read_data, 32'h7FFFFFF0);
      check("top_fault", 32'(fault_sticky), 32'h0);

      do_write(32'h80000000, 32'hAAAA5555);
      check("ovr_fault", 32'(fault_sticky), 32'h1);
      check("ovr_err", 32'(addr_error), 32'h1);
      read_at(32'h7FFF0000);
      check("ovr_base_kept", read_data, 32'hDEADBEEF);
      do_write(32'h7FFEFFFC, 32'h5555AAAA);
      read_at(32'h7FFFFFFC);
      check("und_top_kept", read_data, 32'h12345678);

      // Clear fault, then misaligned store
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("clr_fault", 32'(fault_sticky), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_write(32'h7FFF0002, 32'h0BADF00D);
      check("mis_err", 32'(addr_error), 32'h1);
      check("mis_fault", 32'(fault_sticky), 32'h1);
      read_at(32'h7FFF0000);
      check("mis_base_kept", read_data, 32'hDEADBEEF);

      // Asynchronous reset mid-cycle, away from any edge
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_clr", 32'(fault_sticky), 32'h0);
      check("async_rd", read_data, 32'hDEADBEEF);
      do_write(32'h7FFF0000, 32'h00000000);
      read_at(32'h7FFF0000);
      check("rst_wr_blocked", read_data, 32'hDEADBEEF);
      do_write(32'h80000000, 32'h00000000);
      check("rst_no_fault", 32'(fault_sticky), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_fault", 32'(fault_sticky), 32'h0);

`ifdef DMEM_BYTE_EN
      // Per-lane store and all-lanes-off no-op
      byte_en = 4'b0001;
      do_write(32'h7FFF0000, 32'h000000AA);
      byte_en = 4'hF;
      read_at(32'h7FFF0000);
      check("be_lane0", read_data, 32'hDEADBEAA);
      byte_en = 4'b1000;
      do_write(32'h7FFF0000, 32'h55000000);
      read_at(32'h7FFF0000);
      check("be_lane3", read_data, 32'h55ADBEAA);
      byte_en = 4'b0000;
      do_write(32'h7FFF0000, 32'hFFFFFFFF);
      read_at(32'h7FFF0000);
      check("be_none_rd", read_data, 32'h55ADBEAA);
      check("be_none_fault", 32'(fault_sticky), 32'h0);
      byte_en = 4'hF;
`endif

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
